ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, meaning instruction value driven when no instruction is valid.
REQ-003 clk_i  input  1  meaning single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  meaning reset; one clock, synchronous, active-high.
REQ-005 req_valid_o  output  1  meaning instruction-memory read request valid.
REQ-006 req_ready_i  input  1  meaning memory accepts the request this cycle.
REQ-007 req_addr_o  output  `PC_WIDTH  meaning word-aligned fetch address.
REQ-008 rsp_valid_i  input  1  meaning read data valid; in order; no back-pressure.
REQ-009 rsp_instr_i  input  `INSTR_WIDTH  meaning returned instruction word.
REQ-010 if_valid_o  output  1  meaning instruction available to the if_id register and decode.
REQ-011 if_ready_i  input  1  meaning downstream consumes the instruction this cycle.
REQ-012 if_pc_o  output  `PC_WIDTH  meaning PC of the head instruction.
REQ-013 if_instr_o  output  `INSTR_WIDTH  meaning head instruction word.
REQ-014 redirect_i  input  1  meaning branch or jump taken: flush and refetch.
REQ-015 redirect_pc_i  input  `PC_WIDTH  meaning new fetch target; bits [1:0] ignored and treated as 0.

Function
REQ-016 State: fetch PC register, outstanding counter (0..2), 2-entry FIFO of {pc, instr} with count (0..2), and discard counter (0..2).
REQ-017 Issue rule: req_valid_o is 1 iff not in reset, redirect_i is 0, and outstanding + FIFO count < 2.
REQ-018 A handshake (req_valid_o & req_ready_i) increments outstanding and advances the fetch PC by 4, wrapping modulo 2^32.
REQ-019 req_addr_o equals the fetch PC and stays stable while req_valid_o is 1 and req_ready_i is 0.
REQ-020 A response with discard = 0 writes {issuing pc, rsp_instr_i} to the FIFO tail and decrements outstanding; the data is visible at the head no earlier than the next cycle.
REQ-021 A response with discard > 0 decrements both discard and outstanding and is dropped.
REQ-022 Request and response in the same cycle leave outstanding unchanged.
REQ-023 The FIFO cannot overflow, because the issue rule reserves a slot for each outstanding request; a response arriving with outstanding = 0 is a protocol violation and is ignored.
REQ-024 if_valid_o = (FIFO count > 0); when it is 1, if_pc_o/if_instr_o show the head entry; when it is 0, they show 0/NOP_INSTR.
REQ-025 Pop occurs on if_valid_o & if_ready_i; a simultaneous push and pop keeps the count; a push into an empty FIFO is not bypassed.
REQ-026 Redirect cycle: the FIFO is cleared and no pop occurs; fetch PC <= {redirect_pc_i[31:2], 2'b00}; discard <= outstanding minus any response arriving this cycle; no request is issued.
REQ-027 A response arriving in the redirect cycle is dropped.
REQ-028 A redirect while discard > 0 accumulates correctly: discard always equals the stale in-flight count.
REQ-029 Back-to-back redirects: the last target wins; fetch resumes the cycle after the last redirect.

Reset
REQ-030 While rst_i=1: fetch PC=RESET_PC, outstanding=0, FIFO count=0, discard=0, req_valid_o=0, if_valid_o=0, if_pc_o=0, if_instr_o=NOP_INSTR.
REQ-031 Reset overrides redirect and responses arriving in the same cycle.
REQ-032 A response arriving after reset for a pre-reset request is ignored per REQ-023.
REQ-033 The first request asserts in the first cycle after rst_i falls, with addr=RESET_PC.

Verification
REQ-034 Reset release, req_ready_i=1, 1-cycle memory latency, if_ready_i=1 -> addresses 0,4,8... issued every cycle; if_valid_o is first high 2 cycles after the first request with pc=0.
REQ-035 if_ready_i=0 held -> the FIFO fills to 2, req_valid_o drops to 0 with outstanding=0; releasing if_ready_i delivers pcs 0,4 then 8 with none lost or duplicated.
REQ-036 Redirect to 0x100 with 2 requests outstanding -> the next 2 responses are dropped; the next delivered instruction has pc 0x100, then 0x104.
REQ-037 Redirect with redirect_pc_i=0x203 coincident with a response -> that response is dropped; the next request addr is 0x200.
REQ-038 req_ready_i stalled 3 cycles -> req_addr_o is held constant; no PC skip occurs.
REQ-039 Fetch PC at 0xFFFF_FFFC -> the next request addr is 0x0000_0000.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch stage: issues word-aligned reads, tracks in-flight requests,
// buffers returned words in a 2-entry FIFO and drops responses made stale by a redirect.
module ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [31:0] req_addr_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_instr_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  discard_q, discard_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] infl_pc_q [2];
  logic [31:0] infl_pc_d [2];
  logic        infl_wr_q, infl_wr_d, infl_rd_q, infl_rd_d;
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];
  logic        fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

  logic [2:0]  occupancy;
  logic        req_fire, rsp_fire, push, pop;

  // Each outstanding request owns a FIFO slot, so the FIFO can never overflow.
  assign occupancy   = {1'b0, outstanding_q} + {1'b0, count_q};
  assign req_valid_o = !rst_i && !redirect_i && (occupancy < 3'd2);
  assign req_addr_o  = fetch_pc_q;
  assign req_fire    = req_valid_o && req_ready_i;
  assign rsp_fire    = rsp_valid_i && (outstanding_q != 2'd0);
  assign push        = rsp_fire && !redirect_i && (discard_q == 2'd0);

  assign if_valid_o  = !rst_i && (count_q != 2'd0);
  assign if_pc_o     = if_valid_o ? fifo_pc_q[fifo_rd_q] : 32'd0;
  assign if_instr_o  = if_valid_o ? fifo_instr_q[fifo_rd_q] : NOP_INSTR;
  assign pop         = if_valid_o && if_ready_i && !redirect_i;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    discard_d     = discard_q;
    count_d       = count_q;
    infl_pc_d     = infl_pc_q;
    infl_wr_d     = infl_wr_q;
    infl_rd_d     = infl_rd_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_rd_d     = fifo_rd_q;
    outstanding_d = outstanding_q + {1'b0, req_fire} - {1'b0, rsp_fire};

    // The in-flight PC queue mirrors the outstanding count, stale entries included.
    if (req_fire) begin
      infl_pc_d[infl_wr_q] = fetch_pc_q;
      infl_wr_d            = ~infl_wr_q;
      fetch_pc_d           = fetch_pc_q + 32'd4;
    end
    if (rsp_fire) begin
      infl_rd_d = ~infl_rd_q;
    end

    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      count_d    = 2'd0;
      fifo_wr_d  = 1'b0;
      fifo_rd_d  = 1'b0;
      discard_d  = outstanding_q - {1'b0, rsp_fire};
    end else begin
      if (rsp_fire && (discard_q != 2'd0)) begin
        discard_d = discard_q - 2'd1;
      end
      if (push) begin
        fifo_pc_d[fifo_wr_q]    = infl_pc_q[infl_rd_q];
        fifo_instr_d[fifo_wr_q] = rsp_instr_i;
        fifo_wr_d               = ~fifo_wr_q;
      end
      if (pop) begin
        fifo_rd_d = ~fifo_rd_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 2'd0;
      discard_q     <= 2'd0;
      count_q       <= 2'd0;
      infl_wr_q     <= 1'b0;
      infl_rd_q     <= 1'b0;
      fifo_wr_q     <= 1'b0;
      fifo_rd_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      infl_wr_q     <= infl_wr_d;
      infl_rd_q     <= infl_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
    end
  end

  // Payload storage needs no reset; validity comes from the pointers and counts.
  always_ff @(posedge clk_i) begin
    infl_pc_q    <= infl_pc_d;
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
  end

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch: a queue-based fetch model plus an in-order
// memory with random latency predicts every output each cycle.
module tb_ifetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] rsp_instr_i = 32'd0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b0;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .rsp_valid_i(rsp_valid_i), .rsp_instr_i(rsp_instr_i),
    .if_valid_o(if_valid_o), .if_ready_i(if_ready_i),
    .if_pc_o(if_pc_o), .if_instr_o(if_instr_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  typedef struct { logic [31:0] pc; bit stale; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  infl_t  inflQ[$];
  entry_t fifoQ[$];
  mem_t   memQ[$];
  logic [31:0] fetchPc = RESET_PC;
  int lastDue = -1;

  int compareCount = 0;
  int mismatchCount = 0;
  int cycle = 0;

  int pReady = 100, pIfReady = 100, pRedirect = 0, pReset = 0;
  int minLat = 1, maxLat = 1;
  bit rstReq = 1'b1, forceRedirect = 1'b0, forceStray = 1'b0;
  logic [31:0] forceTarget = 32'd0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h, expected %h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic logic [31:0] pickTarget();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0100;
      1: return 32'h0000_0203;
      2: return 32'hFFFF_FFFC;
      3: return 32'hFFFF_FFF9;
      default: return $urandom;
    endcase
  endfunction

  // Drive one cycle at the falling edge, check predicted outputs, then advance the model.
  task automatic applyStimulus(input int n);
    bit stray, expReq, expIf, pushIt;
    logic [31:0] expPc, expInstr;
    entry_t newE;
    infl_t head;
    int due;
    repeat (n) begin
      @(negedge clk);
      rst_i         = rstReq || ($urandom_range(0, 999) < pReset);
      redirect_i    = forceRedirect || ($urandom_range(0, 99) < pRedirect);
      redirect_pc_i = forceRedirect ? forceTarget : pickTarget();
      forceRedirect = 1'b0;
      req_ready_i   = ($urandom_range(0, 99) < pReady);
      if_ready_i    = ($urandom_range(0, 99) < pIfReady);
      stray         = forceStray;
      forceStray    = 1'b0;
      rsp_instr_i   = $urandom;
      rsp_valid_i   = stray || (memQ.size() > 0 && memQ[0].due <= cycle);
      #1;
      if (rst_i) begin
        expReq = 1'b0; expIf = 1'b0; expPc = 32'd0; expInstr = NOP;
      end else begin
        expReq   = !redirect_i && (inflQ.size() + fifoQ.size() < 2);
        expIf    = fifoQ.size() > 0;
        expPc    = expIf ? fifoQ[0].pc : 32'd0;
        expInstr = expIf ? fifoQ[0].instr : NOP;
      end
      checkOutput("req_valid", {31'd0, req_valid_o}, {31'd0, expReq});
      if (expReq) checkOutput("req_addr", req_addr_o, fetchPc);
      checkOutput("if_valid", {31'd0, if_valid_o}, {31'd0, expIf});
      checkOutput("if_pc", if_pc_o, expPc);
      checkOutput("if_instr", if_instr_o, expInstr);
      @(posedge clk);
      if (rsp_valid_i && !stray && memQ.size() > 0) void'(memQ.pop_front());
      if (rst_i) begin
        fetchPc = RESET_PC;
        inflQ.delete();
        fifoQ.delete();
        memQ.delete();
        lastDue = cycle;
      end else begin
        pushIt = 1'b0;
        if (rsp_valid_i && inflQ.size() > 0) begin
          head = inflQ.pop_front();
          if (!redirect_i && !head.stale) begin
            pushIt = 1'b1;
            newE = '{head.pc, rsp_instr_i};
          end
        end
        if (redirect_i) begin
          fifoQ.delete();
          foreach (inflQ[i]) inflQ[i].stale = 1'b1;
          fetchPc = {redirect_pc_i[31:2], 2'b00};
        end else begin
          if (fifoQ.size() > 0 && if_ready_i) void'(fifoQ.pop_front());
          if (pushIt) fifoQ.push_back(newE);
          if (expReq && req_ready_i) begin
            inflQ.push_back('{fetchPc, 1'b0});
            due = cycle + $urandom_range(minLat, maxLat);
            if (due <= lastDue) due = lastDue + 1;
            memQ.push_back('{fetchPc, due});
            lastDue = due;
            fetchPc = fetchPc + 32'd4;
          end
        end
      end
      cycle++;
    end
  endtask

  initial begin
    applyStimulus(3);
    rstReq = 1'b0;
    forceStray = 1'b1;
    applyStimulus(20);
    pIfReady = 0;
    applyStimulus(12);
    pIfReady = 100;
    applyStimulus(6);
    minLat = 3; maxLat = 3;
    applyStimulus(6);
    forceRedirect = 1'b1; forceTarget = 32'h0000_0100;
    applyStimulus(14);
    minLat = 1; maxLat = 1;
    applyStimulus(4);
    forceRedirect = 1'b1; forceTarget = 32'h0000_0203;
    applyStimulus(6);
    pReady = 0;
    applyStimulus(3);
    pReady = 100;
    applyStimulus(4);
    forceRedirect = 1'b1; forceTarget = 32'hFFFF_FFFC;
    applyStimulus(6);
    forceRedirect = 1'b1; forceTarget = 32'h0000_0500;
    applyStimulus(1);
    forceRedirect = 1'b1; forceTarget = 32'h0000_0600;
    applyStimulus(8);
    pReady = 70; pIfReady = 70; pRedirect = 5; pReset = 5;
    minLat = 1; maxLat = 4;
    applyStimulus(2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
